// File: rtl/control_pkg.sv
// Shared types and constants for the memory arbiter: requester ownership,
// arbitration FSM states, burst limit and the read-return tag format.
package control_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // State records who issued in the previous cycle; it only steers priority.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_OWN   = 2'd1,
        DMA_OWN   = 2'd2,
        DMA_BURST = 2'd3
    } arb_state_t;

    localparam int MAX_BURST   = 4;
    localparam int BURST_CNT_W = $clog2(MAX_BURST + 1);

    // One entry of the read-return pipeline: is a read in flight, and for whom.
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU port, DMA port and memory port of the arbiter.
// slave: the arbiter's view. master: the requesters and memory around it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_wr;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_lock;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_wr, dma_addr, dma_wdata, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_wr, dma_addr, dma_wdata, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational grant selection between CPU and DMA: a held DMA lock wins
// unless the burst limit has tripped, otherwise ties alternate round-robin.
module arb_rr_pick
    import control_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dma_req,
    input  logic   dma_lock,
    input  owner_t last_owner,
    input  logic   burst_limit,
    output logic   cpu_gnt,
    output logic   dma_gnt
);

    logic lock_hold;

    // Pick at most one winner; a grant is only ever given to an active request.
    always_comb begin
        lock_hold = (last_owner == OWN_DMA) && dma_lock && dma_req && !burst_limit;
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        if (lock_hold) begin
            dma_gnt = 1'b1;
        end else if (cpu_req && dma_req) begin
            if (last_owner == OWN_DMA) begin
                cpu_gnt = 1'b1;
            end else begin
                dma_gnt = 1'b1;
            end
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of a synchronous single-port
// memory. Grants are combinational, the memory command is registered one
// cycle after issue, and read data returns to its owner two cycles after issue.
// Optional feature: define MEM_ARB_BURST_LIMIT_EN to cap a locked DMA burst at
// MAX_BURST issues whenever the CPU is waiting; without it the lock is unbounded.
module mem_arbiter
    import control_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
)(
    input  logic         clk,
    input  logic         rst_,
    mem_arbiter_if.slave bus
);

    arb_state_t        state_reg, state_next;
    owner_t            last_owner_reg;
    owner_t            prio_owner;
    logic              cpu_req_act, dma_req_act;
    logic              cpu_gnt, dma_gnt;
    logic              burst_limit;

    logic              issue;
    owner_t            issue_owner;
    logic              issue_wr;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata;

    logic              mem_en_reg, mem_wr_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    rd_tag_t           tag1_reg, tag2_reg;
    logic              cpu_rvalid, dma_rvalid;

    arb_rr_pick u_pick (
        .cpu_req     (cpu_req_act),
        .dma_req     (dma_req_act),
        .dma_lock    (bus.dma_lock),
        .last_owner  (prio_owner),
        .burst_limit (burst_limit),
        .cpu_gnt     (cpu_gnt),
        .dma_gnt     (dma_gnt)
    );

    // FSM state register: owner of the most recent issue, or IDLE.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: classify this cycle's issue (or lack of one).
    always_comb begin
        state_next = IDLE;
        if (cpu_gnt) begin
            state_next = CPU_OWN;
        end else if (dma_gnt) begin
            state_next = bus.dma_lock ? DMA_BURST : DMA_OWN;
        end
    end

    // FSM outputs: priority owner for the picker; requests masked during reset.
    always_comb begin
        cpu_req_act = bus.cpu_req && !rst_;
        dma_req_act = bus.dma_req && !rst_;
        case (state_reg)
            CPU_OWN:            prio_owner = OWN_CPU;
            DMA_OWN, DMA_BURST: prio_owner = OWN_DMA;
            default:            prio_owner = last_owner_reg;
        endcase
    end

    // Remember the last issuer across idle gaps; reset favours the CPU first.
    always_ff @(posedge clk) begin
        if (rst_) begin
            last_owner_reg <= OWN_DMA;
        end else if (issue) begin
            last_owner_reg <= issue_owner;
        end
    end

`ifdef MEM_ARB_BURST_LIMIT_EN
    logic [BURST_CNT_W-1:0] burst_cnt_reg, burst_cnt_next;

    // Count consecutive locked DMA issues (saturating); any other issue clears it.
    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (dma_gnt && bus.dma_lock) begin
            if (burst_cnt_reg < BURST_CNT_W'(MAX_BURST)) begin
                burst_cnt_next = burst_cnt_reg + BURST_CNT_W'(1);
            end
        end else if (issue) begin
            burst_cnt_next = '0;
        end
        burst_limit = (burst_cnt_reg >= BURST_CNT_W'(MAX_BURST)) && bus.cpu_req;
    end

    // Burst counter register.
    always_ff @(posedge clk) begin
        if (rst_) begin
            burst_cnt_reg <= '0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
        end
    end
`else
    assign burst_limit = 1'b0;
`endif

    // Mux the winning requester's command.
    always_comb begin
        issue       = cpu_gnt || dma_gnt;
        issue_owner = dma_gnt ? OWN_DMA : OWN_CPU;
        issue_wr    = dma_gnt ? bus.dma_wr    : bus.cpu_wr;
        issue_addr  = dma_gnt ? bus.dma_addr  : bus.cpu_addr;
        issue_wdata = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
    end

    // Register the memory command so it is presented exactly one cycle after issue.
    always_ff @(posedge clk) begin
        if (rst_) begin
            mem_en_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            mem_en_reg <= issue;
            mem_wr_reg <= issue && issue_wr;
            if (issue) begin
                mem_addr_reg  <= issue_addr;
                mem_wdata_reg <= issue_wdata;
            end
        end
    end

    // Two-stage owner tag pipeline aligning read returns with memory latency.
    always_ff @(posedge clk) begin
        if (rst_) begin
            tag1_reg <= '{valid: 1'b0, owner: OWN_CPU};
            tag2_reg <= '{valid: 1'b0, owner: OWN_CPU};
        end else begin
            tag1_reg <= '{valid: issue && !issue_wr, owner: issue_owner};
            tag2_reg <= tag1_reg;
        end
    end

    // Steer returning data to its owner; everything is forced low while in reset.
    always_comb begin
        cpu_rvalid = tag2_reg.valid && (tag2_reg.owner == OWN_CPU) && !rst_;
        dma_rvalid = tag2_reg.valid && (tag2_reg.owner == OWN_DMA) && !rst_;
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dma_rvalid = dma_rvalid;
    assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.dma_rdata  = dma_rvalid ? bus.mem_rdata : '0;
    assign bus.mem_en     = mem_en_reg && !rst_;
    assign bus.mem_wr     = mem_wr_reg && !rst_;
    assign bus.mem_addr   = rst_ ? '0 : mem_addr_reg;
    assign bus.mem_wdata  = rst_ ? '0 : mem_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenario tasks plus a scoreboard of
// expected read returns checked by a negedge monitor. Honours
// MEM_ARB_BURST_LIMIT_EN for the lock scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import control_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    typedef struct {
        int            due;
        owner_t        owner;
        logic [DW-1:0] data;
    } exp_t;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    exp_t          sb[$];
    logic [DW-1:0] mem_model [2**AW];
    logic [DW-1:0] shadow    [2**AW];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wr) mem_model[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_model[bus.mem_addr];
        end
    end

    // Read-return monitor: every rvalid must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic [DW-1:0] got;
        if (bus.cpu_rvalid || bus.dma_rvalid) begin
            $display("cyc %0d: return cpu_rvalid=%0b dma_rvalid=%0b cpu_rdata=%02h dma_rdata=%02h",
                     cyc, bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, bus.dma_rdata);
            n_checks++;
            if (sb.size() == 0 || sb[0].due != cyc)
                $display("FAIL unexpected_rvalid: got cpu_rvalid=%0b dma_rvalid=%0b, required none at cyc %0d",
                         bus.cpu_rvalid, bus.dma_rvalid, cyc);
            else n_pass++;
        end
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e   = sb.pop_front();
            got = (e.owner == OWN_CPU) ? bus.cpu_rdata : bus.dma_rdata;
            n_checks++;
            if ({bus.cpu_rvalid, bus.dma_rvalid} !== ((e.owner == OWN_CPU) ? 2'b10 : 2'b01) || got !== e.data)
                $display("FAIL read_return: got rvalid{cpu,dma}=%b%b data=%02h, required owner=%s data=%02h",
                         bus.cpu_rvalid, bus.dma_rvalid, got, e.owner.name(), e.data);
            else n_pass++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_wr = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.dma_lock = 1'b0;
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        drive_idle();
        clk_step();
        rst_ = 1'b0;
        sb.delete();
    endtask

    // Record an issued transaction: writes update the shadow, reads expect data.
    task automatic note_issue(input owner_t o, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        $display("cyc %0d: issue owner=%s wr=%0b addr=%02h wdata=%02h", cyc, o.name(), wr, a, d);
        if (wr) shadow[a] = d;
        else begin
            e.due = cyc + 2; e.owner = o; e.data = shadow[a];
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        repeat (3) clk_step();
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b0) $display("FAIL reset_cpu_gnt: got %b required 0", bus.cpu_gnt); else n_pass++;
        n_checks++; if (bus.dma_gnt !== 1'b0) $display("FAIL reset_dma_gnt: got %b required 0", bus.dma_gnt); else n_pass++;
        n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b required 0", bus.mem_en); else n_pass++;
        n_checks++; if (bus.mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b required 0", bus.mem_wr); else n_pass++;
        n_checks++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b%b required 00", bus.cpu_rvalid, bus.dma_rvalid); else n_pass++;
        n_checks++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) $display("FAIL reset_mem_bus: got addr=%02h wdata=%02h required 00/00", bus.mem_addr, bus.mem_wdata); else n_pass++;
        clk_step();
        drive_idle();
        rst_ = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 5'h03;
        @(negedge clk);
        n_checks++; if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b10) $display("FAIL single_gnt: got cpu/dma=%b%b required 10", bus.cpu_gnt, bus.dma_gnt); else n_pass++;
        note_issue(OWN_CPU, 1'b0, 5'h03, '0);
        clk_step();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 5'h03)
            $display("FAIL single_mem_cmd: got en=%b wr=%b addr=%02h required 1/0/03", bus.mem_en, bus.mem_wr, bus.mem_addr); else n_pass++;
        clk_step();
        @(negedge clk);
        n_checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hA5)
            $display("FAIL single_rdata: got rvalid=%b rdata=%02h required 1/a5", bus.cpu_rvalid, bus.cpu_rdata); else n_pass++;
        n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL single_mem_en_off: got %b required 0", bus.mem_en); else n_pass++;
        drain();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] prev_addr = '0;
        logic          exp_cpu;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = AW'(i);
            bus.dma_req = 1'b1; bus.dma_wr = 1'b0; bus.dma_addr = AW'(16 + i); bus.dma_lock = 1'b0;
            @(negedge clk);
            exp_cpu = (i % 2 == 0);
            n_checks++; if ({bus.cpu_gnt, bus.dma_gnt} !== {exp_cpu, !exp_cpu})
                $display("FAIL rr_gnt[%0d]: got cpu/dma=%b%b required %b%b", i, bus.cpu_gnt, bus.dma_gnt, exp_cpu, !exp_cpu); else n_pass++;
            if (i > 0) begin
                n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== prev_addr)
                    $display("FAIL rr_mem[%0d]: got en=%b addr=%02h required 1/%02h", i, bus.mem_en, bus.mem_addr, prev_addr); else n_pass++;
            end
            prev_addr = exp_cpu ? AW'(i) : AW'(16 + i);
            note_issue(exp_cpu ? OWN_CPU : OWN_DMA, 1'b0, prev_addr, '0);
            clk_step();
        end
        drive_idle();
        @(negedge clk);
        n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== prev_addr)
            $display("FAIL rr_mem_last: got en=%b addr=%02h required 1/%02h", bus.mem_en, bus.mem_addr, prev_addr); else n_pass++;
        drain();
    endtask

    task automatic test_lock();
        logic [7:0]    exp_dma;
        logic          d;
        logic [AW-1:0] a;
`ifdef MEM_ARB_BURST_LIMIT_EN
        exp_dma = 8'b1110_1111;
`else
        exp_dma = 8'b1111_1111;
`endif
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = AW'(i);
            bus.dma_req = 1'b1; bus.dma_wr = 1'b0; bus.dma_addr = AW'(8 + i); bus.dma_lock = 1'b1;
            @(negedge clk);
            d = exp_dma[i];
            n_checks++; if ({bus.cpu_gnt, bus.dma_gnt} !== {!d, d})
                $display("FAIL lock_gnt[%0d]: got cpu/dma=%b%b required %b%b", i, bus.cpu_gnt, bus.dma_gnt, !d, d); else n_pass++;
            a = d ? AW'(8 + i) : AW'(i);
            note_issue(d ? OWN_DMA : OWN_CPU, 1'b0, a, '0);
            clk_step();
        end
        drive_idle();
        drain();
    endtask

    task automatic test_dma_write();
        do_reset();
        bus.dma_req = 1'b1; bus.dma_wr = 1'b1; bus.dma_addr = 5'h1F; bus.dma_wdata = 8'h3C;
        @(negedge clk);
        n_checks++; if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b01) $display("FAIL wr_gnt: got cpu/dma=%b%b required 01", bus.cpu_gnt, bus.dma_gnt); else n_pass++;
        note_issue(OWN_DMA, 1'b1, 5'h1F, 8'h3C);
        clk_step();
        drive_idle();
        @(negedge clk);
        n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== 5'h1F || bus.mem_wdata !== 8'h3C)
            $display("FAIL wr_mem_cmd: got en=%b wr=%b addr=%02h wdata=%02h required 1/1/1f/3c",
                     bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata); else n_pass++;
        clk_step();
        @(negedge clk);
        n_checks++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b00) $display("FAIL wr_no_rvalid: got %b%b required 00", bus.cpu_rvalid, bus.dma_rvalid); else n_pass++;
        clk_step();
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 5'h1F;
        @(negedge clk);
        note_issue(OWN_CPU, 1'b0, 5'h1F, '0);
        clk_step();
        drive_idle();
        clk_step();
        @(negedge clk);
        n_checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h3C)
            $display("FAIL wr_readback: got rvalid=%b rdata=%02h required 1/3c", bus.cpu_rvalid, bus.cpu_rdata); else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 5'h03;
        @(negedge clk);
        n_checks++; if (bus.cpu_gnt !== 1'b1) $display("FAIL rstmid_gnt: got %b required 1", bus.cpu_gnt); else n_pass++;
        $display("cyc %0d: issue owner=OWN_CPU read addr=03 (to be discarded by reset)", cyc);
        clk_step();
        rst_ = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.mem_en, bus.mem_wr, bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid} !== 6'b0 || bus.mem_addr !== '0)
            $display("FAIL rstmid_outputs: got en=%b wr=%b gnt=%b%b rvalid=%b%b addr=%02h required all 0",
                     bus.mem_en, bus.mem_wr, bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid, bus.mem_addr); else n_pass++;
        clk_step();
        rst_ = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b00)
                $display("FAIL rstmid_no_rvalid[%0d]: got %b%b required 00", i, bus.cpu_rvalid, bus.dma_rvalid); else n_pass++;
            clk_step();
        end
        bus.cpu_req = 1'b1; bus.cpu_addr = 5'h05;
        bus.dma_req = 1'b1; bus.dma_addr = 5'h06;
        @(negedge clk);
        n_checks++; if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b10) $display("FAIL rstmid_tie: got cpu/dma=%b%b required 10", bus.cpu_gnt, bus.dma_gnt); else n_pass++;
        note_issue(OWN_CPU, 1'b0, 5'h05, '0);
        clk_step();
        drive_idle();
        drain();
    endtask

    task automatic test_drop_req();
        do_reset();
        bus.dma_req = 1'b1; bus.dma_wr = 1'b0; bus.dma_addr = 5'h02; bus.dma_lock = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b01) $display("FAIL drop_gnt0: got cpu/dma=%b%b required 01", bus.cpu_gnt, bus.dma_gnt); else n_pass++;
        note_issue(OWN_DMA, 1'b0, 5'h02, '0);
        clk_step();
        bus.dma_addr = 5'h04;
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 5'h07;
        @(negedge clk);
        n_checks++; if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b01) $display("FAIL drop_gnt1: got cpu/dma=%b%b required 01", bus.cpu_gnt, bus.dma_gnt); else n_pass++;
        note_issue(OWN_DMA, 1'b0, 5'h04, '0);
        clk_step();
        drive_idle();
        @(negedge clk);
        n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 5'h04)
            $display("FAIL drop_mem: got en=%b addr=%02h required 1/04", bus.mem_en, bus.mem_addr); else n_pass++;
        clk_step();
        @(negedge clk);
        n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL drop_no_issue: got mem_en=%b required 0", bus.mem_en); else n_pass++;
        drain();
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem_model[i] = DW'(i * 7 + 8'h11);
            shadow[i]    = DW'(i * 7 + 8'h11);
        end
        mem_model[3] = 8'hA5;
        shadow[3]    = 8'hA5;
        bus.mem_rdata = '0;
        drive_idle();
        rst_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_dma_write();
        test_reset_mid();
        test_drop_req();

        repeat (3) clk_step();
        n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size()); else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
